// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 12;
    localparam int unsigned DEF_DATA_W = 16;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response handshakes for ports F and D plus the RAM-side bus.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = mem_arb_pkg::DEF_ADDR_W,
    parameter int unsigned DATA_W = mem_arb_pkg::DEF_DATA_W
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;

    logic              d_req;
    logic              d_we;
    logic              d_lock;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              lock_err;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data_in;
    logic              ram_write_enable;
    logic              ram_read_enable;
    logic [DATA_W-1:0] ram_data_out;

    // Requesters and the RAM model drive this side.
    modport master (
        output f_req, f_addr, d_req, d_we, d_lock, d_addr, d_wdata, ram_data_out,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, lock_err,
        input  ram_address, ram_data_in, ram_write_enable, ram_read_enable
    );

    // The arbiter sits on this side.
    modport slave (
        input  f_req, f_addr, d_req, d_we, d_lock, d_addr, d_wdata, ram_data_out,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, lock_err,
        output ram_address, ram_data_in, ram_write_enable, ram_read_enable
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker, purely combinational.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // A lone requester wins; on a tie the port that did not win last time goes.
    always_comb begin
        gnt = 2'b00;
        if (req[PORT_F] && req[PORT_D]) begin
            if (last == PORT_D) begin
                gnt[PORT_F] = 1'b1;
            end else begin
                gnt[PORT_D] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM between fetch (F) and load/store (D) with a bounded D lock.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned LOCK_MAX = 8
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);

    localparam int unsigned LOCK_W = 8;

    arb_state_t        state;
    logic              last;
    logic [LOCK_W-1:0] lock_cnt;
    logic              lock_err_q;

    logic [1:0]        req;
    logic [1:0]        rr_gnt;
    logic              f_win;
    logic              d_win;

    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic              we_mux;
    logic              re_mux;

    logic              f_rvalid_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] f_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    // Request vector indexed by port id for the round-robin picker.
    always_comb begin
        req         = 2'b00;
        req[PORT_F] = bus.f_req;
        req[PORT_D] = bus.d_req;
    end

    rr_arb2 u_rr (
        .req  (req),
        .last (last),
        .gnt  (rr_gnt)
    );

    // Final grant: D only while locked, round-robin otherwise, nothing in reset.
    always_comb begin
        f_win = 1'b0;
        d_win = 1'b0;
        if (rst_n) begin
            if (state == LOCKED) begin
                d_win = bus.d_req;
            end else begin
                f_win = rr_gnt[PORT_F];
                d_win = rr_gnt[PORT_D];
            end
        end
    end

    // Route the winner's payload to the RAM; idle bus is all zero.
    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        we_mux    = 1'b0;
        re_mux    = 1'b0;
        if (f_win) begin
            addr_mux = bus.f_addr;
            re_mux   = 1'b1;
        end else if (d_win) begin
            addr_mux  = bus.d_addr;
            wdata_mux = bus.d_wdata;
            we_mux    = bus.d_we;
            re_mux    = !bus.d_we;
        end
    end

    // Arbitration state, round-robin history and lock timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB;
            last       <= PORT_F;
            lock_cnt   <= '0;
            lock_err_q <= 1'b0;
        end else begin
            lock_err_q <= 1'b0;
            if (f_win) last <= PORT_F;
            if (d_win) last <= PORT_D;
            case (state)
                ARB: begin
                    if (d_win && bus.d_lock) begin
                        state    <= LOCKED;
                        lock_cnt <= '0;
                    end
                end
                LOCKED: begin
                    lock_cnt <= lock_cnt + LOCK_W'(1);
                    if (d_win && !bus.d_lock) begin
                        state <= ARB;
                    end else if (lock_cnt == LOCK_W'(LOCK_MAX - 1)) begin
                        // Held for LOCK_MAX cycles: drop it and let F go first.
                        state      <= ARB;
                        lock_err_q <= 1'b1;
                        last       <= PORT_D;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // Capture read data for the granted reader; rvalid follows for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            f_rvalid_q <= f_win;
            d_rvalid_q <= d_win && !bus.d_we;
            if (f_win) f_rdata_q <= bus.ram_data_out;
            if (d_win && !bus.d_we) d_rdata_q <= bus.ram_data_out;
        end
    end

    assign bus.f_gnt            = f_win;
    assign bus.d_gnt            = d_win;
    assign bus.f_rvalid         = f_rvalid_q;
    assign bus.f_rdata          = f_rdata_q;
    assign bus.d_rvalid         = d_rvalid_q;
    assign bus.d_rdata          = d_rdata_q;
    assign bus.lock_err         = lock_err_q;
    assign bus.ram_address      = addr_mux;
    assign bus.ram_data_in      = wdata_mux;
    assign bus.ram_write_enable = we_mux;
    assign bus.ram_read_enable  = re_mux;

endmodule
